// File: rtl/inst_dec_pkg.sv
// Shared definitions for the hxd32 decode/ALU control interface: select encodings,
// opcodes, immediate formats and the registered decode bundle.
package inst_dec_pkg;

    localparam int XLEN = 32;

    localparam logic [2:0] ALU_COMP_BEQ  = 3'b000;
    localparam logic [2:0] ALU_COMP_BNE  = 3'b001;
    localparam logic [2:0] ALU_COMP_NONE = 3'b010;
    localparam logic [2:0] ALU_COMP_BLT  = 3'b100;
    localparam logic [2:0] ALU_COMP_BGE  = 3'b101;
    localparam logic [2:0] ALU_COMP_BLTU = 3'b110;
    localparam logic [2:0] ALU_COMP_BGEU = 3'b111;

    localparam logic [2:0] ALU_OP_1_ADD  = 3'b000;
    localparam logic [2:0] ALU_OP_1_SLL  = 3'b001;
    localparam logic [2:0] ALU_OP_1_SLT  = 3'b010;
    localparam logic [2:0] ALU_OP_1_SLTU = 3'b011;
    localparam logic [2:0] ALU_OP_1_XOR  = 3'b100;
    localparam logic [2:0] ALU_OP_1_SRL  = 3'b101;
    localparam logic [2:0] ALU_OP_1_OR   = 3'b110;
    localparam logic [2:0] ALU_OP_1_AND  = 3'b111;

    localparam logic [1:0] ALU_A_RS1  = 2'b00;
    localparam logic [1:0] ALU_A_PC   = 2'b01;
    localparam logic [1:0] ALU_A_ZERO = 2'b10;

    localparam logic ALU_B_RS2 = 1'b0;
    localparam logic ALU_B_IMM = 1'b1;

    localparam logic [6:0] OPCODE_LOAD     = 7'b0000011;
    localparam logic [6:0] OPCODE_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OPCODE_OP_IMM   = 7'b0010011;
    localparam logic [6:0] OPCODE_AUIPC    = 7'b0010111;
    localparam logic [6:0] OPCODE_STORE    = 7'b0100011;
    localparam logic [6:0] OPCODE_OP       = 7'b0110011;
    localparam logic [6:0] OPCODE_LUI      = 7'b0110111;
    localparam logic [6:0] OPCODE_BRANCH   = 7'b1100011;
    localparam logic [6:0] OPCODE_JALR     = 7'b1100111;
    localparam logic [6:0] OPCODE_JAL      = 7'b1101111;
    localparam logic [6:0] OPCODE_SYSTEM   = 7'b1110011;

    typedef enum logic [2:0] {
        IMM_I = 3'd0,
        IMM_S = 3'd1,
        IMM_B = 3'd2,
        IMM_U = 3'd3,
        IMM_J = 3'd4
    } imm_type_e;

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [2:0]      comp_sel;
        logic            op_0_sel;
        logic [2:0]      op_1_sel;
        logic [1:0]      a_sel;
        logic            b_sel;
        logic [XLEN-1:0] imm;
        logic [4:0]      rs1_addr;
        logic [4:0]      rs2_addr;
        logic [4:0]      rd_addr;
        logic [2:0]      funct3;
        logic            rd_wr_en;
        logic            br_en;
        logic            jmp_en;
        logic            mem_rd_en;
        logic            mem_wr_en;
        logic            illegal;
    } dec_bundle_t;

endpackage

// File: rtl/inst_dec_imm_gen.sv
// Immediate generator: assembles the I/S/B/U/J immediate of an RV32I word and
// sign-extends it from inst[31] to XLEN.
module inst_dec_imm_gen
    import inst_dec_pkg::*;
(
    input  logic [31:0]     i_inst,
    input  imm_type_e       i_imm_type,
    output logic [XLEN-1:0] o_imm
);

    logic [31:0] w_imm32;
    logic        w_unused;

    // opcode bits never contribute to any immediate format
    assign w_unused = ^i_inst[6:0];

    always_comb begin
        w_imm32 = '0;
        case (i_imm_type)
            IMM_I:   w_imm32 = {{20{i_inst[31]}}, i_inst[31:20]};
            IMM_S:   w_imm32 = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
            IMM_B:   w_imm32 = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                                i_inst[11:8], 1'b0};
            IMM_U:   w_imm32 = {i_inst[31:12], 12'b0};
            IMM_J:   w_imm32 = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                                i_inst[30:21], 1'b0};
            default: w_imm32 = '0;
        endcase
    end

    assign o_imm = XLEN'($signed(w_imm32));

endmodule

// File: rtl/inst_dec.sv
// Registered RV32I decoder: decodes one fetched instruction per cycle into the
// ALU control bundle and holds it in a single output stage toward execute.
module inst_dec
    import inst_dec_pkg::*;
(
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            inst_valid_i,
    output logic            inst_ready_o,
    input  logic [31:0]     inst_data_i,
    input  logic [XLEN-1:0] inst_pc_i,
    input  logic            flush_i,
    output logic            dec_valid_o,
    input  logic            dec_ready_i,
    output logic [XLEN-1:0] dec_pc_o,
    output logic [2:0]      alu_comp_sel_o,
    output logic            alu_op_0_sel_o,
    output logic [2:0]      alu_op_1_sel_o,
    output logic [1:0]      alu_a_sel_o,
    output logic            alu_b_sel_o,
    output logic [XLEN-1:0] imm_data_o,
    output logic [4:0]      rs1_addr_o,
    output logic [4:0]      rs2_addr_o,
    output logic [4:0]      rd_addr_o,
    output logic [2:0]      funct3_o,
    output logic            rd_wr_en_o,
    output logic            br_en_o,
    output logic            jmp_en_o,
    output logic            mem_rd_en_o,
    output logic            mem_wr_en_o,
    output logic            illegal_o
);

    logic [6:0]      w_opcode;
    logic [2:0]      w_funct3;
    logic [6:0]      w_funct7;
    imm_type_e       w_imm_type;
    logic [XLEN-1:0] w_imm;
    dec_bundle_t     w_dec;
    logic            w_load;

    dec_bundle_t     r_bundle;
    logic            r_valid;

    assign w_opcode = inst_data_i[6:0];
    assign w_funct3 = inst_data_i[14:12];
    assign w_funct7 = inst_data_i[31:25];

    always_comb begin
        w_imm_type = IMM_I;
        case (w_opcode)
            OPCODE_STORE:              w_imm_type = IMM_S;
            OPCODE_BRANCH:             w_imm_type = IMM_B;
            OPCODE_LUI, OPCODE_AUIPC:  w_imm_type = IMM_U;
            OPCODE_JAL:                w_imm_type = IMM_J;
            default:                   w_imm_type = IMM_I;
        endcase
    end

    inst_dec_imm_gen u_imm_gen (
        .i_inst     (inst_data_i),
        .i_imm_type (w_imm_type),
        .o_imm      (w_imm)
    );

    always_comb begin
        w_dec          = '0;
        w_dec.pc       = inst_pc_i;
        w_dec.comp_sel = ALU_COMP_NONE;
        w_dec.op_1_sel = ALU_OP_1_ADD;
        w_dec.a_sel    = ALU_A_RS1;
        w_dec.b_sel    = ALU_B_RS2;
        w_dec.imm      = w_imm;
        w_dec.rs1_addr = inst_data_i[19:15];
        w_dec.rs2_addr = inst_data_i[24:20];
        w_dec.rd_addr  = inst_data_i[11:7];
        w_dec.funct3   = w_funct3;

        // opcodes all end in 2'b11, so compressed/invalid low bits fall to default
        case (w_opcode)
            OPCODE_OP: begin
                w_dec.op_1_sel = w_funct3;
                w_dec.rd_wr_en = 1'b1;
                if (w_funct7 == 7'b0100000) begin
                    if (w_funct3 == 3'b000 || w_funct3 == 3'b101) w_dec.op_0_sel = 1'b1;
                    else                                          w_dec.illegal  = 1'b1;
                end else if (w_funct7 != 7'b0000000) begin
                    w_dec.illegal = 1'b1;
                end
            end
            OPCODE_OP_IMM: begin
                w_dec.b_sel    = ALU_B_IMM;
                w_dec.op_1_sel = w_funct3;
                w_dec.rd_wr_en = 1'b1;
                if (w_funct3 == 3'b001 && w_funct7 != 7'b0000000) begin
                    w_dec.illegal = 1'b1;
                end else if (w_funct3 == 3'b101) begin
                    if (w_funct7 == 7'b0100000)      w_dec.op_0_sel = inst_data_i[30];
                    else if (w_funct7 != 7'b0000000) w_dec.illegal  = 1'b1;
                end
            end
            OPCODE_LUI: begin
                w_dec.a_sel    = ALU_A_ZERO;
                w_dec.b_sel    = ALU_B_IMM;
                w_dec.rd_wr_en = 1'b1;
            end
            OPCODE_AUIPC: begin
                w_dec.a_sel    = ALU_A_PC;
                w_dec.b_sel    = ALU_B_IMM;
                w_dec.rd_wr_en = 1'b1;
            end
            OPCODE_JAL: begin
                w_dec.a_sel    = ALU_A_PC;
                w_dec.b_sel    = ALU_B_IMM;
                w_dec.jmp_en   = 1'b1;
                w_dec.rd_wr_en = 1'b1;
            end
            OPCODE_JALR: begin
                w_dec.b_sel    = ALU_B_IMM;
                w_dec.jmp_en   = 1'b1;
                w_dec.rd_wr_en = 1'b1;
                w_dec.illegal  = (w_funct3 != 3'b000);
            end
            OPCODE_BRANCH: begin
                w_dec.comp_sel = w_funct3;
                w_dec.br_en    = 1'b1;
                w_dec.illegal  = (w_funct3 == 3'b010 || w_funct3 == 3'b011);
            end
            OPCODE_LOAD: begin
                w_dec.b_sel     = ALU_B_IMM;
                w_dec.mem_rd_en = 1'b1;
                w_dec.rd_wr_en  = 1'b1;
                w_dec.illegal   = (w_funct3 == 3'b011 || w_funct3 == 3'b110 ||
                                   w_funct3 == 3'b111);
            end
            OPCODE_STORE: begin
                w_dec.b_sel     = ALU_B_IMM;
                w_dec.mem_wr_en = 1'b1;
                w_dec.illegal   = (w_funct3 > 3'b010);
            end
            OPCODE_MISC_MEM: ;
            default: w_dec.illegal = 1'b1;
        endcase

        // illegal words still travel downstream so execute can raise the trap
        if (w_dec.illegal) begin
            w_dec.comp_sel  = ALU_COMP_NONE;
            w_dec.rd_wr_en  = 1'b0;
            w_dec.br_en     = 1'b0;
            w_dec.jmp_en    = 1'b0;
            w_dec.mem_rd_en = 1'b0;
            w_dec.mem_wr_en = 1'b0;
        end
        if (w_dec.rd_addr == 5'd0) w_dec.rd_wr_en = 1'b0;
    end

    assign inst_ready_o = !r_valid || dec_ready_i;
    assign w_load       = inst_valid_i && inst_ready_o;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid           <= 1'b0;
            r_bundle          <= '0;
            r_bundle.comp_sel <= ALU_COMP_NONE;
        end else if (flush_i) begin
            r_valid <= 1'b0;
        end else if (w_load) begin
            r_valid  <= 1'b1;
            r_bundle <= w_dec;
        end else if (dec_ready_i) begin
            r_valid <= 1'b0;
        end
    end

    assign dec_valid_o    = r_valid;
    assign dec_pc_o       = r_bundle.pc;
    assign alu_comp_sel_o = r_bundle.comp_sel;
    assign alu_op_0_sel_o = r_bundle.op_0_sel;
    assign alu_op_1_sel_o = r_bundle.op_1_sel;
    assign alu_a_sel_o    = r_bundle.a_sel;
    assign alu_b_sel_o    = r_bundle.b_sel;
    assign imm_data_o     = r_bundle.imm;
    assign rs1_addr_o     = r_bundle.rs1_addr;
    assign rs2_addr_o     = r_bundle.rs2_addr;
    assign rd_addr_o      = r_bundle.rd_addr;
    assign funct3_o       = r_bundle.funct3;
    assign rd_wr_en_o     = r_bundle.rd_wr_en;
    assign br_en_o        = r_bundle.br_en;
    assign jmp_en_o       = r_bundle.jmp_en;
    assign mem_rd_en_o    = r_bundle.mem_rd_en;
    assign mem_wr_en_o    = r_bundle.mem_wr_en;
    assign illegal_o      = r_bundle.illegal;

endmodule

// File: tb/tb_inst_dec.sv
// Directed bench for inst_dec: hand-decoded RV32I words, stall, flush and async reset.
module tb_inst_dec;

    logic        clk_i = 1'b0;
    logic        rst_i;
    logic        inst_valid_i;
    logic        inst_ready_o;
    logic [31:0] inst_data_i;
    logic [31:0] inst_pc_i;
    logic        flush_i;
    logic        dec_valid_o;
    logic        dec_ready_i;
    logic [31:0] dec_pc_o;
    logic [2:0]  alu_comp_sel_o;
    logic        alu_op_0_sel_o;
    logic [2:0]  alu_op_1_sel_o;
    logic [1:0]  alu_a_sel_o;
    logic        alu_b_sel_o;
    logic [31:0] imm_data_o;
    logic [4:0]  rs1_addr_o;
    logic [4:0]  rs2_addr_o;
    logic [4:0]  rd_addr_o;
    logic [2:0]  funct3_o;
    logic        rd_wr_en_o;
    logic        br_en_o;
    logic        jmp_en_o;
    logic        mem_rd_en_o;
    logic        mem_wr_en_o;
    logic        illegal_o;

    int n_checks = 0;
    int n_fail   = 0;

    inst_dec dut (
        .clk_i          (clk_i),
        .rst_i          (rst_i),
        .inst_valid_i   (inst_valid_i),
        .inst_ready_o   (inst_ready_o),
        .inst_data_i    (inst_data_i),
        .inst_pc_i      (inst_pc_i),
        .flush_i        (flush_i),
        .dec_valid_o    (dec_valid_o),
        .dec_ready_i    (dec_ready_i),
        .dec_pc_o       (dec_pc_o),
        .alu_comp_sel_o (alu_comp_sel_o),
        .alu_op_0_sel_o (alu_op_0_sel_o),
        .alu_op_1_sel_o (alu_op_1_sel_o),
        .alu_a_sel_o    (alu_a_sel_o),
        .alu_b_sel_o    (alu_b_sel_o),
        .imm_data_o     (imm_data_o),
        .rs1_addr_o     (rs1_addr_o),
        .rs2_addr_o     (rs2_addr_o),
        .rd_addr_o      (rd_addr_o),
        .funct3_o       (funct3_o),
        .rd_wr_en_o     (rd_wr_en_o),
        .br_en_o        (br_en_o),
        .jmp_en_o       (jmp_en_o),
        .mem_rd_en_o    (mem_rd_en_o),
        .mem_wr_en_o    (mem_wr_en_o),
        .illegal_o      (illegal_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic offer(input logic [31:0] data, input logic [31:0] pc);
        inst_valid_i = 1'b1;
        inst_data_i  = data;
        inst_pc_i    = pc;
    endtask

    initial begin
        rst_i = 1'b1; inst_valid_i = 1'b0; inst_data_i = '0; inst_pc_i = '0;
        flush_i = 1'b0; dec_ready_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1 rst_i = 1'b0;

        chk("rst_valid", 32'(dec_valid_o), 32'd0);
        chk("rst_comp", 32'(alu_comp_sel_o), 32'd2);
        chk("rst_ready", 32'(inst_ready_o), 32'd1);
        chk("rst_imm", imm_data_o, 32'd0);
        chk("rst_rdwr", 32'(rd_wr_en_o), 32'd0);

        dec_ready_i = 1'b1;
        offer(32'h002081B3, 32'h100);                // add x3,x1,x2
        step();
        chk("add_valid", 32'(dec_valid_o), 32'd1);
        chk("add_op1", 32'(alu_op_1_sel_o), 32'd0);
        chk("add_op0", 32'(alu_op_0_sel_o), 32'd0);
        chk("add_a", 32'(alu_a_sel_o), 32'd0);
        chk("add_b", 32'(alu_b_sel_o), 32'd0);
        chk("add_rd", 32'(rd_addr_o), 32'd3);
        chk("add_rs1", 32'(rs1_addr_o), 32'd1);
        chk("add_rs2", 32'(rs2_addr_o), 32'd2);
        chk("add_rdwr", 32'(rd_wr_en_o), 32'd1);
        chk("add_ill", 32'(illegal_o), 32'd0);
        chk("add_pc", dec_pc_o, 32'h100);

        offer(32'h40435293, 32'h104);                // srai x5,x6,4
        step();
        chk("srai_op1", 32'(alu_op_1_sel_o), 32'd5);
        chk("srai_op0", 32'(alu_op_0_sel_o), 32'd1);
        chk("srai_b", 32'(alu_b_sel_o), 32'd1);
        chk("srai_imm", imm_data_o, 32'h404);
        chk("srai_rd", 32'(rd_addr_o), 32'd5);
        chk("srai_pc", dec_pc_o, 32'h104);

        offer(32'hFE435293, 32'h108);                // OP-IMM f3=101 funct7=7F
        step();
        chk("badsh_valid", 32'(dec_valid_o), 32'd1);
        chk("badsh_ill", 32'(illegal_o), 32'd1);
        chk("badsh_rdwr", 32'(rd_wr_en_o), 32'd0);

        offer(32'hFE20ECE3, 32'h10C);                // bltu x1,x2,-8
        step();
        chk("bltu_comp", 32'(alu_comp_sel_o), 32'd6);
        chk("bltu_br", 32'(br_en_o), 32'd1);
        chk("bltu_imm", imm_data_o, 32'hFFFFFFF8);
        chk("bltu_rdwr", 32'(rd_wr_en_o), 32'd0);

        offer(32'h008000EF, 32'h110);                // jal x1,8
        step();
        chk("jal_jmp", 32'(jmp_en_o), 32'd1);
        chk("jal_a", 32'(alu_a_sel_o), 32'd1);
        chk("jal_imm", imm_data_o, 32'd8);
        chk("jal_rdwr", 32'(rd_wr_en_o), 32'd1);
        chk("jal_comp", 32'(alu_comp_sel_o), 32'd2);

        offer(32'hFE20AE23, 32'h114);                // sw x2,-4(x1)
        step();
        chk("sw_wr", 32'(mem_wr_en_o), 32'd1);
        chk("sw_imm", imm_data_o, 32'hFFFFFFFC);
        chk("sw_f3", 32'(funct3_o), 32'd2);
        chk("sw_rdwr", 32'(rd_wr_en_o), 32'd0);

        offer(32'h00013083, 32'h118);                // load funct3=011
        step();
        chk("ld011_ill", 32'(illegal_o), 32'd1);
        chk("ld011_rd", 32'(mem_rd_en_o), 32'd0);

        offer(32'h002081B0, 32'h11C);                // low bits 00
        step();
        chk("lowbits_ill", 32'(illegal_o), 32'd1);
        chk("lowbits_rdwr", 32'(rd_wr_en_o), 32'd0);

        // stall: add held while sub x7,x8,x9 waits
        offer(32'h002081B3, 32'h200);
        step();
        dec_ready_i = 1'b0;
        offer(32'h409403B3, 32'h204);
        #1;
        chk("stall_ready", 32'(inst_ready_o), 32'd0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("stall_valid", 32'(dec_valid_o), 32'd1);
            chk("stall_rd", 32'(rd_addr_o), 32'd3);
            chk("stall_pc", dec_pc_o, 32'h200);
            chk("stall_op0", 32'(alu_op_0_sel_o), 32'd0);
        end
        dec_ready_i = 1'b1;
        #1;
        chk("release_ready", 32'(inst_ready_o), 32'd1);
        step();
        chk("sub_valid", 32'(dec_valid_o), 32'd1);
        chk("sub_rd", 32'(rd_addr_o), 32'd7);
        chk("sub_op0", 32'(alu_op_0_sel_o), 32'd1);
        chk("sub_pc", dec_pc_o, 32'h204);
        inst_valid_i = 1'b0;
        step();
        chk("drain_valid", 32'(dec_valid_o), 32'd0);

        // flush while stalled with a new instruction offered
        offer(32'h002081B3, 32'h300);
        step();
        dec_ready_i = 1'b0;
        offer(32'h008000EF, 32'h304);
        flush_i = 1'b1;
        step();
        chk("flush_valid", 32'(dec_valid_o), 32'd0);
        flush_i = 1'b0;
        inst_valid_i = 1'b0;
        step();
        chk("flush_drop", 32'(dec_valid_o), 32'd0);
        chk("flush_ready", 32'(inst_ready_o), 32'd1);

        // async reset mid-stall
        dec_ready_i = 1'b1;
        offer(32'h40435293, 32'h400);
        step();
        dec_ready_i = 1'b0;
        inst_valid_i = 1'b0;
        step();
        chk("prerst_valid", 32'(dec_valid_o), 32'd1);
        #2 rst_i = 1'b1;
        #1;
        chk("async_valid", 32'(dec_valid_o), 32'd0);
        chk("async_comp", 32'(alu_comp_sel_o), 32'd2);
        chk("async_op1", 32'(alu_op_1_sel_o), 32'd0);
        step();
        rst_i = 1'b0;

        dec_ready_i = 1'b1;
        offer(32'h00001037, 32'h500);                // lui x0,1
        step();
        chk("lui0_valid", 32'(dec_valid_o), 32'd1);
        chk("lui0_rdwr", 32'(rd_wr_en_o), 32'd0);
        chk("lui0_a", 32'(alu_a_sel_o), 32'd2);
        chk("lui0_imm", imm_data_o, 32'h1000);
        chk("lui0_ill", 32'(illegal_o), 32'd0);
        inst_valid_i = 1'b0;
        step();

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
